reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised board bring-up sequencer; successor to the fixed AND of `rst`, PLL lock and SDRAM init-done that gates `ramio` and `core` today. Synchronises N asynchronous "ready" inputs, requires them to be stable for a programmable time, then releases M reset domains in order with a programmable gap. Re-asserts all domains on loss of any ready, counts such events and flags a bring-up timeout. Sits in `top` between clock/SDRAM status and every reset consumer.

## Interface
- `NumReady`, 2: number of ready inputs, ≥1 (e.g. rPLL lock, SDRAM init done).
- `NumDomains`, 2: number of reset domains released in index order, ≥1.
- `StableCycles`, 16: cycles all synchronised readies must stay high before the first release, ≥1.
- `ReleaseGapCycles`, 4: cycles between consecutive domain releases, ≥1.
- `TimeoutCycles`, 27_000_000: bring-up timeout in `clk` cycles (1 s at 27 MHz), ≥1.
- `CountBitWidth`, 8: width of `relock_count`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ready_in`  in  NumReady  asynchronous ready levels.
- `domain_rst_n`  out  NumDomains  active-low reset per domain; bit 0 released first.
- `all_released`  out  1  high while every domain is released.
- `timeout`  out  1  sticky: bring-up exceeded TimeoutCycles.
- `relock_count`  out  CountBitWidth  saturating count of ready losses after a release.

## Operation
- Each `ready_in` bit passes through a 2-flop synchroniser; `ready_s` = AND of all synchronised bits.
- States: WAIT_READY, STABILIZE, RELEASE, RUNNING.
- Reset values: state WAIT_READY, synchroniser flops 0, `domain_rst_n` all 0, `all_released` 0, `timeout` 0, `relock_count` 0, all internal counters 0.
- WAIT_READY: on `ready_s`=1 → STABILIZE, stable counter ← 0.
- STABILIZE: `ready_s`=0 → WAIT_READY. Otherwise, if stable counter = StableCycles-1 → RELEASE, `domain_rst_n[0]` ← 1, domain index ← 0, gap counter ← 0; else stable counter += 1.
- RELEASE: `ready_s`=0 → drop handling (below). Otherwise, if gap counter = ReleaseGapCycles-1, increment domain index and set that bit of `domain_rst_n`, gap counter ← 0; releasing the last domain → RUNNING with `all_released` ← 1 on the same edge. If NumDomains=1, STABILIZE goes straight to RUNNING with `all_released` ← 1.
- RUNNING: hold; `ready_s`=0 → drop handling.
- Drop handling (RELEASE or RUNNING, `ready_s`=0): all `domain_rst_n` ← 0, `all_released` ← 0, `relock_count` += 1 saturating at all-ones, → WAIT_READY. Bits never partially remain released.
- Timeout: counter runs each cycle while no domain has ever been released since `rst`. Reaching TimeoutCycles sets `timeout`=1; it stays set until `rst`. Counting stops at the first release. The sequence continues normally after a timeout.
- `rst` wins over every other event on the same edge, including mid-release.

## Timing
- All outputs are registered; no combinational path from `ready_in` to any output.
- `ready_in` all high set up before edge 0: `ready_s` high after edge 1, STABILIZE after edge 2, `domain_rst_n[0]` high after edge 2+StableCycles, domain i high after edge 2+StableCycles+i·ReleaseGapCycles, `all_released` on the same edge as the last domain.
- Defaults: d0 at edge 18, d1 and `all_released` at edge 22.
- Loss: any `ready_in` low before edge n → all domains low after edge n+2; the new bring-up counts from the restored ready exactly as above.
- A ready glitch shorter than one cycle may be missed; one captured by the synchroniser restarts STABILIZE.

## Test plan
- Defaults, `rst` for 3 cycles, then both readies high → d0 rises at edge 18, d1 and `all_released` at edge 22, `relock_count`=0, `timeout`=0.
- In STABILIZE, drop `ready_in[1]` for 2 cycles at edge 10, then restore → no domain released; d0 rises 18 cycles after restore, `relock_count`=0.
- In RUNNING, drop `ready_in[0]` at edge n → all `domain_rst_n`=0 and `all_released`=0 after edge n+2, `relock_count`=1; re-release after restore. Repeat 300 times with width 8 → count saturates at 255.
- NumDomains=4, ReleaseGapCycles=3, drop a ready between the d1 and d2 releases → all four low together; d2 and d3 never seen high before the restart.
- TimeoutCycles=100, readies held low → `timeout` rises after edge 100 and stays high. Then readies go high → normal release with `timeout` still 1; `rst` clears it.
- Assert `rst` during RELEASE → next edge all outputs at reset values, state WAIT_READY.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board bring-up sequencer: synchronises ready inputs, waits for stability,
// then releases reset domains in index order; any ready loss resets them all.
module reset_sequencer #(
    parameter int NumReady         = 2,
    parameter int NumDomains       = 2,
    parameter int StableCycles     = 16,
    parameter int ReleaseGapCycles = 4,
    parameter int TimeoutCycles    = 27_000_000,
    parameter int CountBitWidth    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumReady-1:0]      ready_in,
    output logic [NumDomains-1:0]    domain_rst_n,
    output logic                     all_released,
    output logic                     timeout,
    output logic [CountBitWidth-1:0] relock_count
);

    localparam int SW = (StableCycles > 1) ? $clog2(StableCycles) : 1;
    localparam int GW = (ReleaseGapCycles > 1) ? $clog2(ReleaseGapCycles) : 1;
    localparam int IW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam int TW = $clog2(TimeoutCycles + 1);

    localparam logic [SW-1:0] StableLast  = SW'(StableCycles - 1);
    localparam logic [GW-1:0] GapLast     = GW'(ReleaseGapCycles - 1);
    localparam logic [IW-1:0] LastIdx     = IW'(NumDomains - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        WAIT_READY,
        STABILIZE,
        RELEASE,
        RUNNING
    } state_t;

    state_t                   r_state, w_state;
    logic [NumReady-1:0]      r_sync1, r_sync2;
    logic [SW-1:0]            r_stable, w_stable;
    logic [GW-1:0]            r_gap, w_gap;
    logic [IW-1:0]            r_idx, w_idx;
    logic [NumDomains-1:0]    r_rst_n, w_rst_n;
    logic                     r_all, w_all;
    logic                     r_timeout, w_timeout;
    logic [TW-1:0]            r_tcnt, w_tcnt;
    logic                     r_ever, w_ever;
    logic [CountBitWidth-1:0] r_count, w_count;
    logic                     w_ready_s;
    logic                     w_drop;

    assign w_ready_s = &r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WAIT_READY;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_rst_n   <= '0;
            r_all     <= 1'b0;
            r_timeout <= 1'b0;
            r_tcnt    <= '0;
            r_ever    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state;
            r_sync1   <= ready_in;
            r_sync2   <= r_sync1;
            r_stable  <= w_stable;
            r_gap     <= w_gap;
            r_idx     <= w_idx;
            r_rst_n   <= w_rst_n;
            r_all     <= w_all;
            r_timeout <= w_timeout;
            r_tcnt    <= w_tcnt;
            r_ever    <= w_ever;
            r_count   <= w_count;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_stable  = r_stable;
        w_gap     = r_gap;
        w_idx     = r_idx;
        w_rst_n   = r_rst_n;
        w_all     = r_all;
        w_timeout = r_timeout;
        w_tcnt    = r_tcnt;
        w_ever    = r_ever;
        w_count   = r_count;
        w_drop    = 1'b0;

        unique case (r_state)
            WAIT_READY: begin
                if (w_ready_s) begin
                    w_state  = STABILIZE;
                    w_stable = '0;
                end
            end
            STABILIZE: begin
                if (!w_ready_s) begin
                    w_state = WAIT_READY;
                end else if (r_stable == StableLast) begin
                    w_rst_n    = '0;
                    w_rst_n[0] = 1'b1;
                    w_idx      = '0;
                    w_gap      = '0;
                    w_ever     = 1'b1;
                    if (NumDomains == 1) begin
                        w_state = RUNNING;
                        w_all   = 1'b1;
                    end else begin
                        w_state = RELEASE;
                    end
                end else begin
                    w_stable = r_stable + SW'(1);
                end
            end
            RELEASE: begin
                if (!w_ready_s) begin
                    w_drop = 1'b1;
                end else if (r_gap == GapLast) begin
                    w_idx          = r_idx + IW'(1);
                    w_rst_n[w_idx] = 1'b1;
                    w_gap          = '0;
                    if (w_idx == LastIdx) begin
                        w_state = RUNNING;
                        w_all   = 1'b1;
                    end
                end else begin
                    w_gap = r_gap + GW'(1);
                end
            end
            RUNNING: begin
                if (!w_ready_s) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state = WAIT_READY;
        endcase

        // A loss mid-release or while running takes every domain down at once
        if (w_drop) begin
            w_state = WAIT_READY;
            w_rst_n = '0;
            w_all   = 1'b0;
            if (r_count != '1) begin
                w_count = r_count + CountBitWidth'(1);
            end
        end

        if (!r_ever && !r_timeout) begin
            w_tcnt = r_tcnt + TW'(1);
            if (r_tcnt == TimeoutLast) begin
                w_timeout = 1'b1;
            end
        end
    end

    assign domain_rst_n = r_rst_n;
    assign all_released = r_all;
    assign timeout      = r_timeout;
    assign relock_count = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance A plus a
// four-domain, short-timeout instance B sharing one clock.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_a, rst_b;
    logic [1:0] ready_a, ready_b;
    logic [1:0] a_rst_n;
    logic [3:0] b_rst_n;
    logic       a_all, b_all, a_tmo, b_tmo;
    logic [7:0] a_cnt, b_cnt;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } ent_t;

    ent_t sb[$];

    reset_sequencer u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .ready_in     (ready_a),
        .domain_rst_n (a_rst_n),
        .all_released (a_all),
        .timeout      (a_tmo),
        .relock_count (a_cnt)
    );

    reset_sequencer #(
        .NumDomains       (4),
        .ReleaseGapCycles (3),
        .TimeoutCycles    (100)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .ready_in     (ready_b),
        .domain_rst_n (b_rst_n),
        .all_released (b_all),
        .timeout      (b_tmo),
        .relock_count (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return 32'(a_rst_n);
            1:       return 32'(a_all);
            2:       return 32'(a_tmo);
            3:       return 32'(a_cnt);
            4:       return 32'(b_rst_n);
            5:       return 32'(b_all);
            6:       return 32'(b_tmo);
            default: return 32'(b_cnt);
        endcase
    endfunction

    task automatic push(input int c, input int sel, input int v,
                        input string tag);
        ent_t e;
        int   i;
        e.cyc = c;
        e.sel = sel;
        e.exp = 32'(v);
        e.tag = tag;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    function automatic int bmask(input int k, input int s);
        int n;
        if (k < s) return 0;
        n = (k - s) / 3 + 1;
        if (n > 4) n = 4;
        return (1 << n) - 1;
    endfunction

    always @(negedge clk) begin
        ent_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run_a();
        int e0, n, r, k;
        rst_a   = 1'b0;
        ready_a = 2'b11;
        e0 = cyc + 1;
        push(e0 + 17, 0, 0, "A_d0_pre");
        push(e0 + 18, 0, 1, "A_d0");
        push(e0 + 21, 0, 1, "A_d1_pre");
        push(e0 + 21, 1, 0, "A_all_pre");
        push(e0 + 22, 0, 3, "A_d1");
        push(e0 + 22, 1, 1, "A_all");
        push(e0 + 22, 3, 0, "A_cnt");
        push(e0 + 22, 2, 0, "A_tmo");
        wait_until(e0 + 24);

        rst_a = 1'b1;
        k = cyc;
        push(k + 1, 0, 0, "A_rst_rstn");
        push(k + 1, 1, 0, "A_rst_all");
        push(k + 1, 3, 0, "A_rst_cnt");
        @(negedge clk);
        rst_a = 1'b0;
        e0 = cyc + 1;
        push(e0 + 18, 0, 0, "A_glitch_hold");
        push(e0 + 29, 0, 0, "A_glitch_pre");
        push(e0 + 30, 0, 1, "A_glitch_d0");
        push(e0 + 34, 0, 3, "A_glitch_d1");
        push(e0 + 34, 1, 1, "A_glitch_all");
        push(e0 + 34, 3, 0, "A_glitch_cnt");
        wait_until(e0 + 9);
        ready_a = 2'b01;
        wait_until(e0 + 11);
        ready_a = 2'b11;
        wait_until(e0 + 36);

        for (int i = 1; i <= 300; i++) begin
            ready_a = 2'b10;
            n = cyc + 1;
            push(n + 1, 0, 3, "A_pre_drop");
            push(n + 2, 0, 0, "A_drop");
            push(n + 2, 1, 0, "A_drop_all");
            push(n + 2, 3, (i > 255) ? 255 : i, "A_relock");
            @(negedge clk);
            @(negedge clk);
            ready_a = 2'b11;
            r = cyc + 1;
            push(r + 17, 0, 0, "A_re_pre");
            push(r + 18, 0, 1, "A_re_d0");
            push(r + 22, 0, 3, "A_re_d1");
            push(r + 22, 1, 1, "A_re_all");
            wait_until(r + 23);
        end
    endtask

    task automatic run_b();
        int c, e0, r, s, q;
        rst_b = 1'b0;
        c = cyc;
        push(c + 99, 6, 0, "B_tmo_pre");
        push(c + 100, 6, 1, "B_tmo");
        push(c + 140, 6, 1, "B_tmo_hold");
        push(c + 140, 4, 0, "B_idle");
        wait_until(c + 150);

        ready_b = 2'b11;
        e0 = cyc + 1;
        s = e0 + 18;
        for (int k = e0 + 16; k <= e0 + 23; k++) push(k, 4, bmask(k, s), "B_rel");
        push(e0 + 23, 6, 1, "B_tmo_rel");
        wait_until(e0 + 21);
        ready_b = 2'b01;
        push(e0 + 24, 4, 0, "B_drop");
        push(e0 + 25, 4, 0, "B_drop");
        push(e0 + 24, 5, 0, "B_drop_all");
        push(e0 + 24, 7, 1, "B_relock");
        push(e0 + 24, 6, 1, "B_tmo_drop");
        wait_until(e0 + 25);
        ready_b = 2'b11;
        r = e0 + 26;
        s = r + 18;
        for (int k = e0 + 26; k <= r + 19; k++) push(k, 4, bmask(k, s), "B_rerel");
        push(r + 19, 6, 1, "B_tmo_keep");
        push(r + 19, 5, 0, "B_all_mid");
        wait_until(r + 19);

        rst_b = 1'b1;
        push(r + 20, 4, 0, "B_rst_rstn");
        push(r + 20, 5, 0, "B_rst_all");
        push(r + 20, 6, 0, "B_rst_tmo");
        push(r + 20, 7, 0, "B_rst_cnt");
        @(negedge clk);
        rst_b = 1'b0;
        q = cyc + 1;
        push(q + 17, 4, 0, "B_post_pre");
        push(q + 18, 4, 1, "B_post_d0");
        push(q + 24, 4, 7, "B_post_d2");
        push(q + 26, 4, 7, "B_post_d2h");
        push(q + 26, 5, 0, "B_post_all_pre");
        push(q + 27, 4, 15, "B_post_d3");
        push(q + 27, 5, 1, "B_post_all");
        push(q + 27, 6, 0, "B_post_tmo");
        wait_until(q + 28);
    endtask

    initial begin
        int guard;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        ready_a = 2'b00;
        ready_b = 2'b00;
        for (int s = 0; s < 8; s++) push(2, s, 0, "reset");
        repeat (3) @(negedge clk);
        fork
            run_a();
            run_b();
        join
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
